// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the multiply-accumulate datapath.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} acc_state_t;

  // Accumulator width: full product plus guard MSBs against carry growth.
  function automatic int acc_width(input int parallelism, input int guard_bits);
    return 2 * parallelism + guard_bits;
  endfunction

endpackage

// File: rtl/mult_accumulator.sv
// Sums a programmed number of unsigned products from the multiplier into a
// guarded accumulator and presents the result over a valid/ready handshake.
module mult_accumulator
  import mult_pkg::*;
#(
  parameter int parallelism = 8,
  parameter int GUARD_BITS  = 8,
  parameter int CNT_WIDTH   = 8,
  localparam int ACC_W      = acc_width(parallelism, GUARD_BITS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [CNT_WIDTH-1:0]     len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2*parallelism-1:0] product,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         acc_out,
  output logic                     overflow,
  output logic                     busy
);

  acc_state_t           state, state_nxt;
  logic [ACC_W-1:0]     acc;
  logic [CNT_WIDTH-1:0] cnt, len_q;
  logic                 ovf;
  logic [ACC_W:0]       sum;
  logic                 take, last;

  // Extra MSB of the sum captures the carry out of the accumulator.
  assign sum  = {1'b0, acc} + (ACC_W+1)'(product);
  assign take = (state == ACCUM) && in_valid;
  assign last = (cnt == CNT_WIDTH'(len_q - 1'b1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len == '0) ? DONE : ACCUM;
      ACCUM:   if (take && last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        acc   <= '0;
        cnt   <= '0;
        len_q <= len;
        ovf   <= 1'b0;
      end else if (take) begin
        acc <= sum[ACC_W-1:0];
        cnt <= cnt + 1'b1;
        if (sum[ACC_W]) ovf <= 1'b1;
      end
    end
  end

  // Handshake outputs decode from state only, so no input-to-output paths.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign acc_out   = acc;
  assign overflow  = ovf;

endmodule

// File: tb/tb_mult_accumulator.sv
// Directed bench: main instance (ACC_W=24) and a narrow-guard instance
// (ACC_W=17) share all inputs so the wrap case is seen on the latter.
module tb_mult_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        in_valid = 1'b0;
  logic [15:0] product = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, overflow, busy;
  logic [23:0] acc_out;
  logic        g_in_ready, g_out_valid, g_overflow, g_busy;
  logic [16:0] g_acc_out;

  int n_cmp = 0;
  int n_err = 0;

  mult_accumulator #(.parallelism(8), .GUARD_BITS(8), .CNT_WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .product(product),
    .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
    .overflow(overflow), .busy(busy)
  );

  mult_accumulator #(.parallelism(8), .GUARD_BITS(1), .CNT_WIDTH(8)) u_g1 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(g_in_ready), .product(product),
    .out_valid(g_out_valid), .out_ready(out_ready), .acc_out(g_acc_out),
    .overflow(g_overflow), .busy(g_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_cmp++;
    if ({in_ready, out_valid, overflow, busy} !== 4'b0) begin
      n_err++; $display("FAIL reset_flags: got %b expected 0000", {in_ready, out_valid, overflow, busy});
    end
    n_cmp++;
    if (acc_out !== 24'd0) begin
      n_err++; $display("FAIL reset_acc: got %0d expected 0", acc_out);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    start = 1'b1; len = 8'd3;
    step();
    start = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL basic_ready: got in_ready=%b busy=%b expected 1 1", in_ready, busy);
    end
    in_valid = 1'b1; product = 16'h0121;
    step(); step();
    n_cmp++;
    if (out_valid !== 1'b0 || acc_out !== 24'd578) begin
      n_err++; $display("FAIL basic_partial: got out_valid=%b acc=%0d expected 0 578", out_valid, acc_out);
    end
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || acc_out !== 24'd867 || overflow !== 1'b0 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL basic_done: got ov=%b acc=%0d ovf=%b rdy=%b expected 1 867 0 0",
                        out_valid, acc_out, overflow, in_ready);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL basic_idle: got out_valid=%b busy=%b expected 0 0", out_valid, busy);
    end
  endtask

  task automatic test_bubbles();
    start = 1'b1; len = 8'd4;
    step();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1; product = 16'(k);
      step();
      in_valid = 1'b0;
      if (k < 4) step();
      if (k == 1) begin
        n_cmp++;
        if (acc_out !== 24'd1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
          n_err++; $display("FAIL bubble_hold: got acc=%0d rdy=%b ov=%b expected 1 1 0", acc_out, in_ready, out_valid);
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || acc_out !== 24'd10 || in_ready !== 1'b0) begin
        n_err++; $display("FAIL backpressure_%0d: got ov=%b acc=%0d rdy=%b expected 1 10 0",
                          i, out_valid, acc_out, in_ready);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL bubble_idle: got ov=%b busy=%b expected 0 0", out_valid, busy);
    end
  endtask

  task automatic test_overflow();
    start = 1'b1; len = 8'd3;
    step();
    start = 1'b0;
    in_valid = 1'b1; product = 16'd65025;
    step(); step();
    n_cmp++;
    if (g_overflow !== 1'b0 || g_acc_out !== 17'd130050) begin
      n_err++; $display("FAIL ovf_partial: got acc=%0d ovf=%b expected 130050 0", g_acc_out, g_overflow);
    end
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (g_out_valid !== 1'b1 || g_acc_out !== 17'd64003 || g_overflow !== 1'b1) begin
      n_err++; $display("FAIL ovf_wrap: got ov=%b acc=%0d ovf=%b expected 1 64003 1", g_out_valid, g_acc_out, g_overflow);
    end
    n_cmp++;
    if (acc_out !== 24'd195075 || overflow !== 1'b0) begin
      n_err++; $display("FAIL ovf_wide: got acc=%0d ovf=%b expected 195075 0", acc_out, overflow);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    start = 1'b1; len = 8'd1;
    step();
    start = 1'b0;
    n_cmp++;
    if (g_overflow !== 1'b0 || g_acc_out !== 17'd0) begin
      n_err++; $display("FAIL ovf_clear: got acc=%0d ovf=%b expected 0 0", g_acc_out, g_overflow);
    end
    in_valid = 1'b1; product = 16'd1;
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_zero_len();
    start = 1'b1; len = 8'd0;
    step();
    start = 1'b0;
    in_valid = 1'b1; product = 16'd5;
    n_cmp++;
    if (out_valid !== 1'b1 || acc_out !== 24'd0 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL zero_len: got ov=%b acc=%0d rdy=%b expected 1 0 0", out_valid, acc_out, in_ready);
    end
    step();
    n_cmp++;
    if (acc_out !== 24'd0 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL zero_len_hold: got acc=%0d rdy=%b expected 0 0", acc_out, in_ready);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL zero_len_idle: got ov=%b busy=%b expected 0 0", out_valid, busy);
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; len = 8'd5;
    step();
    start = 1'b0;
    in_valid = 1'b1; product = 16'd3;
    step(); step();
    in_valid = 1'b0;
    n_cmp++;
    if (acc_out !== 24'd6 || busy !== 1'b1) begin
      n_err++; $display("FAIL mid_partial: got acc=%0d busy=%b expected 6 1", acc_out, busy);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, overflow, busy} !== 4'b0 || acc_out !== 24'd0) begin
      n_err++; $display("FAIL mid_reset: got flags=%b acc=%0d expected 0000 0",
                        {in_ready, out_valid, overflow, busy}, acc_out);
    end
    step();
    rst_n = 1'b1;
    start = 1'b1; len = 8'd1;
    step();
    start = 1'b0;
    in_valid = 1'b1; product = 16'd7;
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || acc_out !== 24'd7) begin
      n_err++; $display("FAIL mid_newjob: got ov=%b acc=%0d expected 1 7", out_valid, acc_out);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_start_ignored();
    start = 1'b1; len = 8'd2;
    step();
    start = 1'b0;
    in_valid = 1'b1; product = 16'd10;
    step();
    start = 1'b1; len = 8'd5; product = 16'd20;
    step();
    start = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || acc_out !== 24'd30) begin
      n_err++; $display("FAIL ign_accum: got ov=%b acc=%0d expected 1 30", out_valid, acc_out);
    end
    start = 1'b1; len = 8'd1;
    step();
    start = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || acc_out !== 24'd30 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL ign_done: got ov=%b acc=%0d rdy=%b expected 1 30 0", out_valid, acc_out, in_ready);
    end
    start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0; out_ready = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || acc_out !== 24'd30) begin
      n_err++; $display("FAIL ign_exit: got busy=%b acc=%0d expected 0 30", busy, acc_out);
    end
    step();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL ign_stay_idle: got busy=%b expected 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubbles();
    test_overflow();
    test_zero_len();
    test_reset_mid();
    test_start_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult_accumulator.md
# mult_accumulator

Sequential accumulation stage downstream of the combinational `multiplier` (any `ARCH_TYPE`). It consumes a stream of unsigned `2*parallelism`-bit products over a valid/ready handshake and sums a programmed number of them into a guarded accumulator. It then presents the registered sum on an output handshake. Together with the multiplier it forms the dot-product/MAC datapath.

## Interface
- `parallelism`, 8, operand width of the upstream multiplier; product width is `2*parallelism`.
- `GUARD_BITS`, 8, extra accumulator MSBs; `ACC_W = 2*parallelism + GUARD_BITS`.
- `CNT_WIDTH`, 8, width of the length field and internal counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a new accumulation; sampled only in IDLE.
- `len`  in  CNT_WIDTH  number of products to accumulate; latched on `start`.
- `in_valid`  in  1  `product` is valid.
- `in_ready`  out  1  block accepts a product this cycle.
- `product`  in  2*parallelism  unsigned product from the multiplier.
- `out_valid`  out  1  `acc_out` holds a final sum.
- `out_ready`  in  1  consumer takes the result.
- `acc_out`  out  ACC_W  accumulated sum, registered.
- `overflow`  out  1  sticky; sum exceeded `2^ACC_W - 1` during this job.
- `busy`  out  1  high in ACCUM and DONE.

## Operation
- FSM states: IDLE, ACCUM, DONE.
- **IDLE**
  - `in_ready`=0, `out_valid`=0.
  - `start`=1 with `len`≠0: latch `len`, clear acc, counter and `overflow`, go to ACCUM.
  - `start`=1 with `len`=0: clear acc and `overflow`, go directly to DONE.
- **ACCUM**
  - `in_ready`=1.
  - On each `in_valid && in_ready`: `acc <= acc + zero_ext(product)` modulo `2^ACC_W`, and `cnt <= cnt + 1`.
  - A carry out of bit `ACC_W-1` sets `overflow`, which stays set until the next accepted `start`.
  - On the handshake where `cnt == len-1`, go to DONE.
  - `in_valid`=0 cycles are bubbles: no state change.
- **DONE**
  - `out_valid`=1; `acc_out` and `overflow` are held stable.
  - On `out_ready`=1, go to IDLE.
  - `in_ready`=0.
- `start` is ignored outside IDLE.
- A `start` in the same cycle as the DONE→IDLE transition is not accepted; it must be reasserted in IDLE.
- `acc_out` always shows the accumulator register, including partial sums during ACCUM. Consumers use it only when `out_valid`=1.
- Arithmetic is unsigned. The product is zero-extended by `GUARD_BITS` before the add. No saturation: the sum wraps.

## Timing
- Reset values: state=IDLE, `in_ready`=0, `out_valid`=0, `acc_out`=0, `overflow`=0, `busy`=0, counter=0.
- An asynchronous `rst_n` assertion in any state aborts the job immediately. The partial sum is discarded.
- All outputs are registered or decoded from state only; there is no combinational path from `in_valid` or `out_ready` to any output.
- `start` in cycle t makes `in_ready`=1 in cycle t+1.
- The last product accepted at edge t gives `out_valid`=1 and the final `acc_out` after edge t, with no extra pipeline stage.
- Throughput: one product per cycle; a job of N products occupies N+1 cycles minimum, plus the output wait.
- `len`=0: `out_valid` is set one cycle after `start`, with `acc_out`=0.

## Structure
- Shared package `mult_pkg`:
  - `typedef enum logic [1:0] {IDLE, ACCUM, DONE} acc_state_t`.
  - Function/localparam for `ACC_W` from `parallelism` and `GUARD_BITS`.
- Single module, with no sub-modules: the adder with carry-out, the counter and the FSM are inline.
- The multiplier instance stays outside; the system level wires its `product` port to this block.

## Test plan
- Basic sum, `parallelism`=8: `start`, `len`=3, three back-to-back products 0x0121 (17×17) → `out_valid` the cycle after the third handshake, `acc_out`=867, `overflow`=0.
- Bubbles and output backpressure: `len`=4, products 1,2,3,4 with `in_valid` low every other cycle, `out_ready` held low 5 cycles → `acc_out`=10 stable all 5 cycles, `in_ready`=0 throughout DONE, and IDLE on the cycle after `out_ready` rises.
- Overflow wrap, with `GUARD_BITS`=1 (`ACC_W`=17): `len`=3, product 65025 each → `acc_out`=64003, `overflow`=1. A following `start` clears `overflow`.
- Zero length: `start`, `len`=0 → `out_valid` the next cycle with `acc_out`=0; `in_ready` never asserts.
- Reset mid-job: `len`=5, two products accepted, then `rst_n` low for 1 cycle → all outputs return to reset values immediately. A new job with `len`=1 and product 7 → `acc_out`=7.
- Start ignored: pulse `start` during ACCUM and during DONE → job length and result unchanged.
